// File: rtl/serial_receiver.sv
// serial_receiver: deserialises a frame-strobe / bit-clock / data link into parallel words.
// Define SERIAL_RECEIVER_PARITY_EN to expect a trailing even-parity bit and expose parity_error.
module serial_receiver #(
  parameter int WIDTH = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   transmission,
  input  logic                   transmission_clock,
  input  logic                   in_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic                   frame_error,
`ifdef SERIAL_RECEIVER_PARITY_EN
  output logic                   parity_error,
`endif
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic                   busy
);
`ifdef SERIAL_RECEIVER_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int SW = FRAME_BITS - 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, RECEIVE, WAIT_END} state_t;
  state_t state, state_n;
  logic [1:0] tx_sy, sclk_sy, data_sy, prime;
  logic tx_s, sclk_s, data_s, sclk_d, sclk_rise, armed;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic good, start, shift, last, short_err, extra_err;
  assign tx_s = tx_sy[1];
  assign sclk_s = sclk_sy[1];
  assign data_s = data_sy[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign busy = state != IDLE;
`ifdef SERIAL_RECEIVER_PARITY_EN
  assign word = shreg;
  assign good = ~^{shreg, data_s};
`else
  assign word = {shreg, data_s};
  assign good = 1'b1;
`endif
  always_comb begin
    state_n = state;
    start = 1'b0;
    shift = 1'b0;
    last = 1'b0;
    short_err = 1'b0;
    extra_err = 1'b0;
    case (state)
      IDLE: if (tx_s && armed) begin
        state_n = RECEIVE;
        start = 1'b1;
      end
      RECEIVE: if (!tx_s) begin
        short_err = 1'b1;
        state_n = IDLE;
      end else if (sclk_rise) begin
        shift = 1'b1;
        last = bit_cnt == BW'(FRAME_BITS - 1);
        state_n = last ? WAIT_END : RECEIVE;
      end
      WAIT_END: if (!tx_s) state_n = IDLE;
                else extra_err = sclk_rise;
      default: state_n = IDLE;
    endcase
  end
  // prime masks the synchroniser's post-reset zeros so a frame in flight at reset release cannot arm
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sy <= '0;
      sclk_sy <= '0;
      data_sy <= '0;
      prime <= '0;
      sclk_d <= 1'b0;
      armed <= 1'b0;
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
`ifdef SERIAL_RECEIVER_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      tx_sy <= {tx_sy[0], transmission};
      sclk_sy <= {sclk_sy[0], transmission_clock};
      data_sy <= {data_sy[0], in_data};
      prime <= {prime[0], 1'b1};
      sclk_d <= sclk_s;
      armed <= armed | (~tx_s & prime[1]);
      state <= state_n;
      bit_cnt <= start ? '0 : shift ? bit_cnt + 1'b1 : bit_cnt;
      shreg <= start ? '0 : shift ? {shreg[SW-2:0], data_s} : shreg;
      out_valid <= last & good;
      out_data <= last & good ? word : out_data;
      frame_count <= last & good ? frame_count + 1'b1 : frame_count;
      frame_error <= short_err | extra_err;
`ifdef SERIAL_RECEIVER_PARITY_EN
      parity_error <= last & ~good;
`endif
    end
  end
endmodule
